pixel_framebuffer: RTL and testbench
====================================

# pixel_framebuffer

Receiving end of the pixel-plot interface driven by the box and clear-screen drawers: accepts one pixel write per cycle (X, Y, colour, plot strobe) into an on-chip frame store of 3-bit pixels. A raster scanner reads the frame back in row-major order on request, for the display path and for bench checking. The block replaces the VGA adapter as the plot sink in simulation and in the reduced-size test build.

## Interface
- X_SCREEN_PIXELS, 160: frame width in pixels (8 for testing)
- Y_SCREEN_PIXELS, 120: frame height in pixels (5 for testing)
- iClock  in  1  single clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iX  in  8  plot X coordinate
- iY  in  7  plot Y coordinate
- iColour  in  3  plot colour
- iPlot  in  1  pixel write strobe, one pixel per high cycle
- iStartScan  in  1  start a full-frame read-back (honoured in IDLE only)
- oX  out  8  X of pixel on oColour
- oY  out  7  Y of pixel on oColour
- oColour  out  3  read-back colour
- oValid  out  1  oX/oY/oColour valid this cycle
- oScanDone  out  1  one-cycle pulse with the last valid pixel of a scan
- oBusy  out  1  scanner not in IDLE
- oDropCount  out  8  saturating count of out-of-range writes

## Operation
- Write port: on an edge with iPlot=1 and iX<X_SCREEN_PIXELS and iY<Y_SCREEN_PIXELS, mem[iY*X_SCREEN_PIXELS+iX] <= iColour. Address width is clog2(X*Y); the product is formed at full width with no truncation.
- An out-of-range write leaves memory unchanged and increments oDropCount, which saturates at 255.
- Writes are accepted in every scanner state, including mid-scan.
- Scanner FSM has three states: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on iStartScan; the scan counters (sx, sy) load 0,0.
  - SCAN issues a read of (sx,sy) each cycle. sx increments; at sx=X-1 it wraps to 0 and sy increments. On issuing (X-1,Y-1) the FSM → DRAIN.
  - DRAIN → IDLE unconditionally.
  - iStartScan outside IDLE is ignored, not queued.
- Read data are registered. oX/oY/oColour/oValid come out one cycle after the address issue, with oX/oY pipelined alongside the colour.
- oScanDone=1 in the same cycle as oValid for (X-1,Y-1).
- oBusy=1 in SCAN and DRAIN.
- Read/write collision: a read and a write to the same address in the same cycle returns the old data (read-before-write). The new value is visible to any later read.
- Memory contents are not cleared by reset; clearing is the drawer's job via its black-fill.

## Timing
- Reset values: oX=0, oY=0, oColour=0, oValid=0, oScanDone=0, oBusy=0, oDropCount=0; FSM IDLE; scan counters 0.
- Reset mid-scan: the next cycle is IDLE with all outputs at reset values, and no oScanDone pulse.
- Write latency: a write at edge k is readable by a read issued at edge k+1 or later.
- Scan latency, with iStartScan sampled at edge 0 and N=X*Y:
  - SCAN is entered at edge 0.
  - The first read issues in cycle 1.
  - oValid for (0,0) appears in cycle 2.
  - oValid for the last pixel and oScanDone appear in cycle N+1.
  - IDLE is re-entered at cycle N+2.
  - The earliest next start is sampled at the end of cycle N+2.
- oValid is continuous (no gaps) for exactly N cycles per scan.

## Structure
- Shared package fb_pkg holds:
  - screen size defaults
  - COLOUR_W=3, X_W=8, Y_W=7
  - the scanner state encoding
  - an addr_of(x,y,width) function
- Sub-module fb_ram: simple dual-port RAM with one synchronous write port, one synchronous read port and read-before-write. It is sized X*Y×3 so it infers block RAM.
- Top level holds the range check, drop counter, FSM, scan counters and output pipeline.

## Test plan
- Reset, with parameters 8×5: all outputs zero. Assert iStartScan during reset → no oValid for 10 cycles after release.
- Plot (3,2)=5 and (7,4)=6, then scan:
  - exactly 40 oValid cycles
  - pixel 19 reports (3,2) colour 5
  - pixel 39 reports (7,4) colour 6, with oScanDone high
  - oBusy falls the next cycle
- Plot (8,0) and (0,5), then plot (200,127): oDropCount=3, and a scan shows unchanged memory. Drive 300 out-of-range writes → oDropCount=255.
- Collision: during a scan, write (2,0)=7 in the cycle the scanner issues (2,0). Read-back shows the old value; a second scan shows 7.
- Assert iStartScan again at cycles 5 and 20 of a running scan → still exactly 40 valid pixels, with one oScanDone.
- Assert iReset at scan pixel 12 → oValid=0 and oBusy=0 next cycle, no oScanDone. A fresh scan completes normally with memory contents intact.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants for the pixel framebuffer: screen defaults, field widths,
// scanner state encoding and the row-major address helper.
package fb_pkg;

  localparam int X_SCREEN_DEFAULT = 160;
  localparam int Y_SCREEN_DEFAULT = 120;

  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Full 32-bit product so the row offset never wraps before the caller narrows it.
  function automatic logic [31:0] addr_of(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] width);
    return (y * width) + x;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame store: one synchronous write port, one registered
// read port returning the pre-write contents on a same-address collision.
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read of mem_q gives read-before-write without extra bypass logic.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_framebuffer.sv
// Plot sink with on-chip frame store: range-checked pixel writes, a drop
// counter, and a row-major raster scanner that reads the frame back.
module pixel_framebuffer
  import fb_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = X_SCREEN_DEFAULT,
  parameter int Y_SCREEN_PIXELS = Y_SCREEN_DEFAULT
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [X_W-1:0]      iX,
  input  logic [Y_W-1:0]      iY,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iPlot,
  input  logic                iStartScan,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oValid,
  output logic                oScanDone,
  output logic                oBusy,
  output logic [7:0]          oDropCount
);

  localparam int NPIX   = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic [1:0]          state_q, state_d;
  logic [X_W-1:0]      sx_q, sx_d;
  logic [Y_W-1:0]      sy_q, sy_d;
  logic [7:0]          dropCount_q, dropCount_d;
  logic                valid_q, done_q;
  logic [X_W-1:0]      outX_q;
  logic [Y_W-1:0]      outY_q;

  logic                inRange;
  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic [ADDR_W-1:0]   rdAddr;
  logic [COLOUR_W-1:0] ramData;
  logic                scanning;
  logic                lastX, lastY;

  assign inRange  = (32'(iX) < 32'(X_SCREEN_PIXELS)) && (32'(iY) < 32'(Y_SCREEN_PIXELS));
  assign wrEn     = iPlot && inRange;
  assign wrAddr   = ADDR_W'(addr_of(32'(iX), 32'(iY), 32'(X_SCREEN_PIXELS)));
  assign rdAddr   = ADDR_W'(addr_of(32'(sx_q), 32'(sy_q), 32'(X_SCREEN_PIXELS)));
  assign scanning = (state_q == ST_SCAN);
  assign lastX    = (32'(sx_q) == 32'(X_SCREEN_PIXELS - 1));
  assign lastY    = (32'(sy_q) == 32'(Y_SCREEN_PIXELS - 1));

  fb_ram #(
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOUR_W)
  ) u_ram (
    .clk_i   (iClock),
    .we_i    (wrEn),
    .waddr_i (wrAddr),
    .wdata_i (iColour),
    .raddr_i (rdAddr),
    .rdata_o (ramData)
  );

  // Scanner walks row-major; a start request is only looked at from IDLE.
  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    dropCount_d = dropCount_q;
    case (state_q)
      ST_IDLE: begin
        if (iStartScan) begin
          state_d = ST_SCAN;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      ST_SCAN: begin
        if (lastX) begin
          sx_d = '0;
          if (lastY) begin
            state_d = ST_DRAIN;
          end else begin
            sy_d = sy_q + Y_W'(1);
          end
        end else begin
          sx_d = sx_q + X_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (iPlot && !inRange && (dropCount_q != 8'hFF)) begin
      dropCount_d = dropCount_q + 8'd1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      sx_q        <= '0;
      sy_q        <= '0;
      dropCount_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      outX_q      <= '0;
      outY_q      <= '0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      dropCount_q <= dropCount_d;
      valid_q     <= scanning;
      done_q      <= scanning && lastX && lastY;
      outX_q      <= sx_q;
      outY_q      <= sy_q;
    end
  end

  // The RAM read register is not reset, so colour is masked outside valid pixels.
  assign oColour    = valid_q ? ramData : '0;
  assign oX         = outX_q;
  assign oY         = outY_q;
  assign oValid     = valid_q;
  assign oScanDone  = done_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oDropCount = dropCount_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Randomised bench for pixel_framebuffer at 8x5: a frame array plus a
// saturating drop counter model predict every scan read-back.
module tb_pixel_framebuffer;

  localparam int XS = 8;
  localparam int YS = 5;
  localparam int N  = XS * YS;

  logic       iClock;
  logic       iReset;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iPlot;
  logic       iStartScan;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oValid;
  logic       oScanDone;
  logic       oBusy;
  logic [7:0] oDropCount;

  logic [2:0] model [N];
  int         dropModel;
  int         checkCount;
  int         passCount;

  pixel_framebuffer #(
    .X_SCREEN_PIXELS (XS),
    .Y_SCREEN_PIXELS (YS)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iX         (iX),
    .iY         (iY),
    .iColour    (iColour),
    .iPlot      (iPlot),
    .iStartScan (iStartScan),
    .oX         (oX),
    .oY         (oY),
    .oColour    (oColour),
    .oValid     (oValid),
    .oScanDone  (oScanDone),
    .oBusy      (oBusy),
    .oDropCount (oDropCount)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic stepClock;
    @(posedge iClock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One plot cycle; the model writes in-range pixels and counts the rest.
  task automatic applyStimulus(input int x, input int y, input logic [2:0] col);
    iX      = 8'(x);
    iY      = 7'(y);
    iColour = col;
    iPlot   = 1'b1;
    stepClock();
    iPlot   = 1'b0;
    if (x < XS && y < YS) begin
      model[y * XS + x] = col;
    end else if (dropModel < 255) begin
      dropModel++;
    end
  endtask

  // Runs one scan, optionally colliding a write with pixel (2,0), re-requesting
  // a start mid-scan, or resetting right after pixel 12 is seen.
  task automatic runScan(input string tag, input bit collide, input bit restart, input bit resetMid);
    logic [2:0]  expected [N];
    logic [31:0] want;
    int          idx, doneCount, doneIdx, firstC, lastC;
    bit          resetHit;
    for (int i = 0; i < N; i++) expected[i] = model[i];
    idx = 0; doneCount = 0; doneIdx = -1; firstC = -1; lastC = -1; resetHit = 0;
    iStartScan = 1'b1;
    stepClock();
    iStartScan = 1'b0;
    for (int c = 1; c <= N + 4; c++) begin
      if (resetHit) begin
        checkOutput({tag, " rst valid"}, 32'(oValid), 32'd0);
        checkOutput({tag, " rst busy"}, 32'(oBusy), 32'd0);
        checkOutput({tag, " rst done"}, 32'(oScanDone), 32'd0);
        checkOutput({tag, " rst xy"}, {17'd0, oX, oY}, 32'd0);
        iReset   = 1'b0;
        resetHit = 0;
      end else if (oValid) begin
        if (firstC < 0) firstC = c;
        lastC = c;
        if (idx < N) begin
          want = {14'd0, 8'(idx % XS), 7'(idx / XS), expected[idx]};
          checkOutput({tag, " pixel"}, {14'd0, oX, oY, oColour}, want);
        end
        if (oScanDone) begin
          doneCount++;
          doneIdx = idx;
        end
        idx++;
      end else if (oScanDone) begin
        doneCount++;
      end
      if (!resetMid && c == N + 1) checkOutput({tag, " busy last"}, 32'(oBusy), 32'd1);
      if (!resetMid && c == N + 2) checkOutput({tag, " busy fall"}, 32'(oBusy), 32'd0);
      iPlot      = 1'b0;
      iStartScan = 1'b0;
      if (collide && c == 3) begin
        iX = 8'd2; iY = 7'd0; iColour = 3'd7; iPlot = 1'b1;
      end
      if (restart && (c == 5 || c == 20)) iStartScan = 1'b1;
      if (resetMid && oValid && idx == 13) begin
        iReset    = 1'b1;
        resetHit  = 1;
        dropModel = 0;
      end
      stepClock();
    end
    iPlot = 1'b0;
    if (collide) model[2] = 3'd7;
    if (resetMid) begin
      checkOutput({tag, " pixels"}, 32'(idx), 32'd13);
      checkOutput({tag, " done count"}, 32'(doneCount), 32'd0);
    end else begin
      checkOutput({tag, " pixels"}, 32'(idx), 32'(N));
      checkOutput({tag, " done count"}, 32'(doneCount), 32'd1);
      checkOutput({tag, " done pixel"}, 32'(doneIdx), 32'(N - 1));
      checkOutput({tag, " first cycle"}, 32'(firstC), 32'd2);
      checkOutput({tag, " last cycle"}, 32'(lastC), 32'(N + 1));
    end
  endtask

  initial begin
    checkCount = 0; passCount = 0; dropModel = 0;
    iReset = 1'b1; iStartScan = 1'b1; iPlot = 1'b0;
    iX = '0; iY = '0; iColour = '0;
    for (int i = 0; i < N; i++) model[i] = 3'd0;
    repeat (3) stepClock();
    checkOutput("reset outputs", {6'd0, oX, oY, oColour, oValid, oScanDone, oBusy}, 32'd0);
    checkOutput("reset drops", 32'(oDropCount), 32'd0);
    iReset = 1'b0; iStartScan = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("post reset valid", 32'(oValid), 32'd0);
      checkOutput("post reset busy", 32'(oBusy), 32'd0);
      stepClock();
    end

    for (int i = 0; i < N; i++) applyStimulus(i % XS, i / XS, 3'($urandom_range(0, 7)));
    applyStimulus(2, 0, 3'd1);
    applyStimulus(3, 2, 3'd5);
    applyStimulus(7, 4, 3'd6);
    runScan("basic", 0, 0, 0);

    applyStimulus(8, 0, 3'd3);
    applyStimulus(0, 5, 3'd3);
    checkOutput("drops two", 32'(oDropCount), 32'(dropModel));
    applyStimulus(200, 127, 3'd2);
    checkOutput("drops three", 32'(oDropCount), 32'd3);
    runScan("after drops", 0, 0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(XS + $urandom_range(0, 247), $urandom_range(0, 127), 3'($urandom));
    checkOutput("drops saturate", 32'(oDropCount), 32'd255);

    runScan("collide", 1, 0, 0);
    runScan("post collide", 0, 0, 0);
    runScan("restart ignored", 0, 1, 0);

    for (int i = 0; i < 60; i++) applyStimulus($urandom_range(0, 9), $urandom_range(0, 6), 3'($urandom_range(0, 7)));
    checkOutput("random drops", 32'(oDropCount), 32'(dropModel));
    runScan("random", 0, 0, 0);

    runScan("reset mid", 0, 0, 1);
    checkOutput("drops after reset", 32'(oDropCount), 32'(dropModel));
    runScan("after reset", 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
